spi_slave_shift_reg: RTL and testbench

SPI slave (target) datapath: the responder end of the link driven by the SPI master shift register.
- Oversamples the external sclk, ss_n and mosi on the system clock.
- Shifts one character of programmable length in from mosi and out on miso, supporting all four CPOL/CPHA modes and MSB- or LSB-first order.
- Presents received characters and accepts transmit characters through simple valid/ready handshakes to the host-side register block.

---
 rtl/spi_slave_shift_reg_if.sv | 40 ++++
 rtl/spi_slave_shift_reg.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_shift_reg.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_shift_reg_if.sv
// ----------------------------------------------------------------------------
// spi_slave_shift_reg_if: SPI pins, mode controls and host handshakes.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_slave_shift_reg_if #(
  parameter int MAX_CHAR = 32,
  parameter int LEN_BITS = 5
);
  logic                sclk_in;
  logic                ss_n;
  logic                mosi;
  logic                miso;
  logic                miso_oe;
  logic                cpol;
  logic                cpha;
  logic                lsb;
  logic [LEN_BITS-1:0] len;
  logic [MAX_CHAR-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [MAX_CHAR-1:0] rx_data;
  logic                rx_valid;
  logic                busy;
  logic                tx_underrun;
  logic                frame_err;

  modport slave (
    input  sclk_in, ss_n, mosi, cpol, cpha, lsb, len, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err
  );

  modport master (
    output sclk_in, ss_n, mosi, cpol, cpha, lsb, len, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave_shift_reg.sv
// ----------------------------------------------------------------------------
// spi_slave_shift_reg: oversampled SPI target datapath, all CPOL/CPHA modes.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_shift_reg #(
  parameter int MAX_CHAR = 32,
  parameter int LEN_BITS = 5
) (
  input  wire logic            wb_clk_in,
  input  wire logic            wb_rst,
  spi_slave_shift_reg_if.slave bus
);

  localparam int CNT_W = LEN_BITS + 1;
  localparam int IDX_W = (MAX_CHAR > 1) ? $clog2(MAX_CHAR) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic                ss_meta_q, ss_sync_q, ss_prev_q;
  logic                mosi_meta_q, mosi_sync_q;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_CHAR-1:0] tx_sr_q, tx_sr_d;
  logic [MAX_CHAR-1:0] rx_sr_q, rx_sr_d;
  logic [MAX_CHAR-1:0] txbuf_q, txbuf_d;
  logic                txfull_q, txfull_d;
  logic [MAX_CHAR-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                frame_err_q, frame_err_d;

  logic [CNT_W-1:0]    w_char_len;
  logic [IDX_W-1:0]    w_top_idx;
  logic [MAX_CHAR-1:0] w_mask;
  logic [MAX_CHAR-1:0] w_rx_next;
  logic                w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic                w_sample, w_shift, w_ss_fall, w_ss_rise, w_tx_wr;

  always_comb begin
    w_char_len  = (len_q == '0) ? CNT_W'(MAX_CHAR) : {1'b0, len_q};
    w_top_idx   = IDX_W'(w_char_len - CNT_W'(1));
    w_sclk_rise = sclk_sync_q & ~sclk_prev_q;
    w_sclk_fall = ~sclk_sync_q & sclk_prev_q;
    w_lead      = cpol_q ? w_sclk_fall : w_sclk_rise;
    w_trail     = cpol_q ? w_sclk_rise : w_sclk_fall;
    w_sample    = cpha_q ? w_trail : w_lead;
    w_shift     = cpha_q ? w_lead : w_trail;
    w_ss_fall   = ~ss_sync_q & ss_prev_q;
    w_ss_rise   = ss_sync_q & ~ss_prev_q;
    w_tx_wr     = bus.tx_valid & ~txfull_q;
    for (int i = 0; i < MAX_CHAR; i++) begin
      w_mask[i] = (i < int'(w_char_len));
    end
    // LSB-first fills from the top of the character and drifts down to bit 0
    w_rx_next = lsb_q ? (rx_sr_q >> 1) : {rx_sr_q[MAX_CHAR-2:0], 1'b0};
    if (lsb_q) begin
      w_rx_next[w_top_idx] = mosi_sync_q;
    end else begin
      w_rx_next[0] = mosi_sync_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    lsb_d         = lsb_q;
    len_d         = len_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    txbuf_d       = txbuf_q;
    txfull_d      = txfull_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;

    if (w_tx_wr) begin
      txbuf_d  = bus.tx_data;
      txfull_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (w_ss_fall) begin
          state_d = ACTIVE;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          lsb_d   = bus.lsb;
          len_d   = bus.len;
          first_d = bus.cpha;
          cnt_d   = '0;
          rx_sr_d = '0;
          if (txfull_q) begin
            tx_sr_d  = txbuf_q;
            txfull_d = 1'b0;
          end else begin
            tx_sr_d       = '0;
            tx_underrun_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          // With cpha=1 the opening shift edge only presents bit 0
          if (w_shift) begin
            if (first_q) begin
              first_d = 1'b0;
            end else begin
              tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
          end
          if (w_sample) begin
            rx_sr_d = w_rx_next;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == w_char_len - CNT_W'(1)) begin
              rx_data_d  = w_rx_next & w_mask;
              rx_valid_d = 1'b1;
              state_d    = DONE;
            end
          end
        end
      end
      DONE: begin
        if (w_ss_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      sclk_meta_q   <= 1'b0;
      sclk_sync_q   <= 1'b0;
      sclk_prev_q   <= 1'b0;
      ss_meta_q     <= 1'b1;
      ss_sync_q     <= 1'b1;
      ss_prev_q     <= 1'b1;
      mosi_meta_q   <= 1'b0;
      mosi_sync_q   <= 1'b0;
      state_q       <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      len_q         <= '0;
      first_q       <= 1'b0;
      cnt_q         <= '0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      txbuf_q       <= '0;
      txfull_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sclk_meta_q   <= bus.sclk_in;
      sclk_sync_q   <= sclk_meta_q;
      sclk_prev_q   <= sclk_sync_q;
      ss_meta_q     <= bus.ss_n;
      ss_sync_q     <= ss_meta_q;
      ss_prev_q     <= ss_sync_q;
      mosi_meta_q   <= bus.mosi;
      mosi_sync_q   <= mosi_meta_q;
      state_q       <= state_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      lsb_q         <= lsb_d;
      len_q         <= len_d;
      first_q       <= first_d;
      cnt_q         <= cnt_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      txbuf_q       <= txbuf_d;
      txfull_q      <= txfull_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.miso        = (state_q != IDLE) & (lsb_q ? tx_sr_q[0] : tx_sr_q[w_top_idx]);
  assign bus.miso_oe     = (state_q != IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_ready    = ~txfull_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_shift_reg: bit-banged SPI master against a frame-level model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_shift_reg;

  localparam int MAX_CHAR = 32;
  localparam int LEN_BITS = 5;
  localparam int HALF     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_shift_reg_if #(.MAX_CHAR(MAX_CHAR), .LEN_BITS(LEN_BITS)) bus();

  spi_slave_shift_reg #(.MAX_CHAR(MAX_CHAR), .LEN_BITS(LEN_BITS)) dut (
    .wb_clk_in (clk),
    .wb_rst    (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_rxv  = 0;
  int n_und  = 0;
  int n_ferr = 0;
  logic [31:0] m_rx      = '0;
  logic [31:0] m_pending = '0;
  bit          mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] maskn(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // k-th bit on the wire of an n-bit character
  function automatic logic wire_bit(input logic [31:0] v, input int n, input bit l, input int k);
    return l ? v[k] : v[n-1-k];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid)    n_rxv++;
      if (bus.tx_underrun) n_und++;
      if (bus.frame_err)   n_ferr++;
      if (rst) begin
        m_rx = '0;
      end else if (mon_en) begin
        if (bus.rx_valid) begin
          check("rx_data_on_valid", bus.rx_data, m_pending);
          m_rx = m_pending;
        end else begin
          check("rx_data_held", bus.rx_data, m_rx);
        end
        check("miso_oe_vs_busy", 32'(bus.miso_oe), 32'(bus.busy));
      end
    end
  end

  task automatic tx_write(input logic [31:0] v);
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic frame(input bit cp, input bit ch, input bit l, input logic [4:0] ln,
                       input logic [31:0] tx_exp, input logic [31:0] mo, input int nsend,
                       output logic [31:0] rec);
    int   n;
    logic rb;
    n        = (ln == 5'd0) ? 32 : int'(ln);
    bus.cpol = cp;
    bus.cpha = ch;
    bus.lsb  = l;
    bus.len  = ln;
    bus.sclk_in = cp;
    cyc(8);
    m_pending = mo & maskn(n);
    rec = '0;
    bus.ss_n = 1'b0;
    bus.mosi = wire_bit(mo, n, l, 0);
    cyc(2*HALF);
    check("tx_ready_after_start", 32'(bus.tx_ready), 32'd1);
    for (int k = 0; k < nsend; k++) begin
      if (!ch) begin
        rb = bus.miso;
        bus.sclk_in = ~cp;
        cyc(HALF);
        bus.sclk_in = cp;
        if (k + 1 < n) bus.mosi = wire_bit(mo, n, l, k + 1);
        cyc(HALF);
      end else begin
        bus.sclk_in = ~cp;
        bus.mosi = wire_bit(mo, n, l, k);
        cyc(HALF);
        rb = bus.miso;
        bus.sclk_in = cp;
        cyc(HALF);
      end
      check("miso_bit", 32'(rb), 32'(wire_bit(tx_exp, n, l, k)));
      rec = {rec[30:0], rb};
    end
    cyc(2*HALF);
    check("busy_before_ss_rise", 32'(bus.busy), 32'd1);
    bus.ss_n = 1'b1;
    cyc(8);
    check("busy_after_ss_rise", 32'(bus.busy), 32'd0);
    check("miso_oe_after_ss_rise", 32'(bus.miso_oe), 32'd0);
  endtask

  initial begin
    logic [31:0] rw;
    int rxv0, und0, ferr0;
    bus.sclk_in  = 1'b0;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.lsb      = 1'b0;
    bus.len      = '0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    cyc(3);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", bus.rx_data, 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Mode 0, MSB first, 8 bits
    tx_write(32'hA5);
    check("t1_tx_ready_after_write", 32'(bus.tx_ready), 32'd0);
    rxv0 = n_rxv; und0 = n_und;
    frame(1'b0, 1'b0, 1'b0, 5'd8, 32'hA5, 32'h3C, 8, rw);
    check("t1_miso_stream", rw, 32'h0000_00A5);
    check("t1_rx_data", bus.rx_data, 32'h0000_003C);
    check("t1_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);
    check("t1_no_underrun", 32'(n_und - und0), 32'd0);

    // Mode 3, LSB first, 4 bits
    tx_write(32'h6);
    rxv0 = n_rxv;
    frame(1'b1, 1'b1, 1'b1, 5'd4, 32'h6, 32'h9, 4, rw);
    check("t2_miso_stream", rw, 32'h6);
    check("t2_rx_data", bus.rx_data, 32'h9);
    check("t2_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);

    // Mode 1, len=0 -> full 32-bit character
    tx_write(32'hDEAD_BEEF);
    frame(1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32, rw);
    check("t3_miso_stream", rw, 32'hDEAD_BEEF);
    check("t3_rx_data", bus.rx_data, 32'h1234_5678);

    // Empty buffer at frame start
    rxv0 = n_rxv; und0 = n_und;
    frame(1'b0, 1'b0, 1'b0, 5'd8, 32'h0, 32'hC3, 8, rw);
    check("t4_miso_zero", rw, 32'h0);
    check("t4_underrun_pulses", 32'(n_und - und0), 32'd1);
    check("t4_rx_data", bus.rx_data, 32'hC3);
    check("t4_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);

    // Aborted frame after 5 of 8 bits, then a clean frame
    tx_write(32'h5A);
    rxv0 = n_rxv; ferr0 = n_ferr;
    frame(1'b0, 1'b0, 1'b0, 5'd8, 32'h5A, 32'h77, 5, rw);
    check("t5_frame_err_pulses", 32'(n_ferr - ferr0), 32'd1);
    check("t5_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
    check("t5_rx_data_kept", bus.rx_data, 32'hC3);
    tx_write(32'h81);
    rxv0 = n_rxv; ferr0 = n_ferr;
    frame(1'b0, 1'b0, 1'b0, 5'd8, 32'h81, 32'h7E, 8, rw);
    check("t5_next_miso", rw, 32'h81);
    check("t5_next_rx_data", bus.rx_data, 32'h7E);
    check("t5_next_rx_valid", 32'(n_rxv - rxv0), 32'd1);
    check("t5_next_no_ferr", 32'(n_ferr - ferr0), 32'd0);

    // Reset mid-frame after 3 bits
    tx_write(32'hFF);
    rxv0 = n_rxv; ferr0 = n_ferr;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb = 1'b0; bus.len = 5'd8;
    bus.sclk_in = 1'b0;
    cyc(8);
    bus.ss_n = 1'b0;
    bus.mosi = 1'b1;
    cyc(2*HALF);
    for (int k = 0; k < 3; k++) begin
      bus.sclk_in = 1'b1;
      cyc(HALF);
      bus.sclk_in = 1'b0;
      cyc(HALF);
    end
    check("t6_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.ss_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_miso", 32'(bus.miso), 32'd0);
    check("t6_miso_oe", 32'(bus.miso_oe), 32'd0);
    check("t6_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("t6_rx_data", bus.rx_data, 32'd0);
    check("t6_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    check("t6_frame_err", 32'(bus.frame_err), 32'd0);
    cyc(4);
    rst = 1'b0;
    cyc(10);
    check("t6_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
    check("t6_no_frame_err", 32'(n_ferr - ferr0), 32'd0);
    tx_write(32'h33);
    rxv0 = n_rxv;
    frame(1'b1, 1'b0, 1'b0, 5'd8, 32'h33, 32'h99, 8, rw);
    check("t6_after_miso", rw, 32'h33);
    check("t6_after_rx_data", bus.rx_data, 32'h99);
    check("t6_after_rx_valid", 32'(n_rxv - rxv0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
